mem_port_arbiter: RTL

//  Parametrised RAM-port owner for the ROMulator core.
//  - Muxes the shared image RAM between three masters: flash loader, CPU bus and diagnostics.
//  - Sequences them through load, run, drain and halt phases.
//  - Drives CPU ready from the current phase.
//  - Decodes NUM_WIN programmable write windows (video-RAM style) for the CPU/diag write stream.

---
 rtl/mem_port_arbiter_if.sv | 69 ++++++
 rtl/mem_port_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - signal bundle between mem_port_arbiter and its masters/RAM
//
// Purpose: groups the loader, CPU, diagnostics, window-programming inputs and
// the registered RAM-port / window / phase-flag outputs of mem_port_arbiter.
// Ports (all logic):
//   loader : load_addr, load_wdata, load_cs, load_we, load_done
//   cpu    : cpu_addr, cpu_wdata, cpu_cs, cpu_we, cpu_active
//   diag   : diag_halt_req, diag_addr, diag_wdata, diag_cs, diag_we
//   window : win_prog, win_idx, win_start, win_end
//   ram    : ram_addr, ram_wdata, ram_cs, ram_we
//   decode : win_hit, win_off, win_wr
//   flags  : cpu_rdy, halted, loaded
// Modports: slave = arbiter side, master = environment side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int NUM_WIN = 4,
  parameter int WOFF_W  = 11
);
  logic [ADDR_W-1:0]  load_addr;
  logic [DATA_W-1:0]  load_wdata;
  logic               load_cs;
  logic               load_we;
  logic               load_done;
  logic [ADDR_W-1:0]  cpu_addr;
  logic [DATA_W-1:0]  cpu_wdata;
  logic               cpu_cs;
  logic               cpu_we;
  logic               cpu_active;
  logic               diag_halt_req;
  logic [ADDR_W-1:0]  diag_addr;
  logic [DATA_W-1:0]  diag_wdata;
  logic               diag_cs;
  logic               diag_we;
  logic               win_prog;
  logic [3:0]         win_idx;
  logic [ADDR_W-1:0]  win_start;
  logic [ADDR_W-1:0]  win_end;
  logic [ADDR_W-1:0]  ram_addr;
  logic [DATA_W-1:0]  ram_wdata;
  logic               ram_cs;
  logic               ram_we;
  logic [NUM_WIN-1:0] win_hit;
  logic [WOFF_W-1:0]  win_off;
  logic               win_wr;
  logic               cpu_rdy;
  logic               halted;
  logic               loaded;

  modport slave (
    input  load_addr, load_wdata, load_cs, load_we, load_done,
    input  cpu_addr, cpu_wdata, cpu_cs, cpu_we, cpu_active,
    input  diag_halt_req, diag_addr, diag_wdata, diag_cs, diag_we,
    input  win_prog, win_idx, win_start, win_end,
    output ram_addr, ram_wdata, ram_cs, ram_we,
    output win_hit, win_off, win_wr,
    output cpu_rdy, halted, loaded
  );

  modport master (
    output load_addr, load_wdata, load_cs, load_we, load_done,
    output cpu_addr, cpu_wdata, cpu_cs, cpu_we, cpu_active,
    output diag_halt_req, diag_addr, diag_wdata, diag_cs, diag_we,
    output win_prog, win_idx, win_start, win_end,
    input  ram_addr, ram_wdata, ram_cs, ram_we,
    input  win_hit, win_off, win_wr,
    input  cpu_rdy, halted, loaded
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - image-RAM port owner: load/run/drain/halt sequencing and write-window decode
//
// Purpose: muxes the shared image RAM between flash loader (LOAD), CPU
// (RUN/DRAIN) and diagnostics (HALT); registers the selected master onto the
// RAM port with one cycle of latency; decodes NUM_WIN programmable windows on
// the selected address.
// Ports:
//   clk  - system clock
//   rst  - asynchronous reset, active-high
//   bus  - mem_port_arbiter_if.slave (master inputs, ram_*, win_*, flags)
// Optional feature macro: ROMULATOR_BANK_REG_EN (bank-select write at
// BANK_ADDR reported as a window-0 hit).
module mem_port_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int NUM_WIN   = 4,
  parameter int WOFF_W    = 11,
  parameter int DRAIN_MAX = 255,
  parameter int BANK_ADDR = 59468
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam int                CNT_W  = $clog2(DRAIN_MAX + 1);
  localparam logic [ADDR_W-1:0] BANK_A = ADDR_W'(BANK_ADDR);
`ifdef ROMULATOR_BANK_REG_EN
  localparam bit BANK_EN = 1'b1;
`else
  localparam bit BANK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  win_start_q [NUM_WIN];
  logic [ADDR_W-1:0]  win_end_q   [NUM_WIN];

  logic [ADDR_W-1:0]  ram_addr_q;
  logic [DATA_W-1:0]  ram_wdata_q;
  logic               ram_cs_q, ram_we_q;
  logic [NUM_WIN-1:0] win_hit_q;
  logic [WOFF_W-1:0]  win_off_q;
  logic               win_wr_q;
  logic               cpu_rdy_q, halted_q, loaded_q;

  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               sel_cs, sel_we;
  logic [NUM_WIN-1:0] hit_d;
  logic [WOFF_W-1:0]  off_d;
  logic               wr_d;

  // A dropped halt request wins over a same-cycle halt condition in DRAIN:
  // the requester no longer wants the bus, so the CPU keeps running.
  always_comb begin : fsm_next
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_LOAD:  if (bus.load_done) state_d = S_RUN;
      S_RUN:   if (bus.diag_halt_req) state_d = S_DRAIN;
      S_DRAIN: begin
        if (!bus.diag_halt_req) begin
          state_d = S_RUN;
        end else if (!bus.cpu_active || cnt_q == CNT_W'(DRAIN_MAX)) begin
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HALT:  if (!bus.diag_halt_req) state_d = S_RUN;
      default: state_d = S_LOAD;
    endcase
  end

  // Owner follows the current state so the switch lands on the first cycle
  // of the new state.
  always_comb begin : port_mux
    sel_addr  = bus.cpu_addr;
    sel_wdata = bus.cpu_wdata;
    sel_cs    = bus.cpu_cs;
    sel_we    = bus.cpu_we;
    case (state_q)
      S_LOAD: begin
        sel_addr  = bus.load_addr;
        sel_wdata = bus.load_wdata;
        sel_cs    = bus.load_cs;
        sel_we    = bus.load_we;
      end
      S_HALT: begin
        sel_addr  = bus.diag_addr;
        sel_wdata = bus.diag_wdata;
        sel_cs    = bus.diag_cs;
        sel_we    = bus.diag_we;
      end
      default: ;
    endcase
  end

  // Scan from the top index down so the lowest matching index is left last.
  // start>=end can never satisfy start<=addr<end, so disabled windows drop out.
  always_comb begin : win_decode
    hit_d = '0;
    off_d = '0;
    for (int i = NUM_WIN - 1; i >= 0; i--) begin
      if (win_start_q[i] <= sel_addr && sel_addr < win_end_q[i]) begin
        hit_d    = '0;
        hit_d[i] = 1'b1;
        off_d    = WOFF_W'(sel_addr - win_start_q[i]);
      end
    end
    if (BANK_EN && sel_we && sel_addr == BANK_A && win_start_q[0] < win_end_q[0]) begin
      hit_d = NUM_WIN'(1);
      off_d = WOFF_W'(win_end_q[0] - win_start_q[0] - ADDR_W'(1));
    end
    wr_d = sel_we && (hit_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_LOAD;
      cnt_q       <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_cs_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      win_hit_q   <= '0;
      win_off_q   <= '0;
      win_wr_q    <= 1'b0;
      cpu_rdy_q   <= 1'b0;
      halted_q    <= 1'b0;
      loaded_q    <= 1'b0;
      for (int i = 0; i < NUM_WIN; i++) begin
        win_start_q[i] <= '0;
        win_end_q[i]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ram_addr_q  <= sel_addr;
      ram_wdata_q <= sel_wdata;
      ram_cs_q    <= sel_cs;
      ram_we_q    <= sel_we;
      win_hit_q   <= hit_d;
      win_off_q   <= off_d;
      win_wr_q    <= wr_d;
      cpu_rdy_q   <= (state_d == S_RUN) || (state_d == S_DRAIN);
      halted_q    <= (state_d == S_HALT);
      loaded_q    <= (state_d != S_LOAD);
      for (int i = 0; i < NUM_WIN; i++) begin
        if (bus.win_prog && bus.win_idx == 4'(i)) begin
          win_start_q[i] <= bus.win_start;
          win_end_q[i]   <= bus.win_end;
        end
      end
    end
  end

  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.ram_cs    = ram_cs_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.win_hit   = win_hit_q;
  assign bus.win_off   = win_off_q;
  assign bus.win_wr    = win_wr_q;
  assign bus.cpu_rdy   = cpu_rdy_q;
  assign bus.halted    = halted_q;
  assign bus.loaded    = loaded_q;
endmodule
